// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : control_sequencer
// Purpose  : Multi-cycle control FSM for the 32-bit microprocessor. It steps
//            each instruction through FETCH, DECODE, EXECUTE, MEMORY and
//            WRITEBACK, drives the datapath enables and the shared memory
//            port handshake, and counts retired instructions.
// Ports    : clk, resetN (async, active low)
//            run          - allows FETCH to issue a new request
//            opcode       - IR[31:26]
//            aluZero      - ALU zero flag, used by beq in EXECUTE
//            memReady     - memory completes the current request this cycle
//            memReq/memWrite/memSel          - memory port control
//            irWrite/pcWrite/pcSrc           - IR / PC load control
//            aluSrcImm/regWrite/memToReg     - datapath control
//            state/halted/fault/retiredCount - status
// Revision : 1.0 - initial release
// ============================================================================
module control_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   run,
    input  logic [5:0]             opcode,
    input  logic                   aluZero,
    input  logic                   memReady,
    output logic                   memReq,
    output logic                   memWrite,
    output logic                   memSel,
    output logic                   irWrite,
    output logic                   pcWrite,
    output logic [1:0]             pcSrc,
    output logic                   aluSrcImm,
    output logic                   regWrite,
    output logic                   memToReg,
    output logic [2:0]             state,
    output logic                   halted,
    output logic                   fault,
    output logic [COUNT_WIDTH-1:0] retiredCount
);

    localparam logic [2:0] c_st_fetch     = 3'd0;
    localparam logic [2:0] c_st_decode    = 3'd1;
    localparam logic [2:0] c_st_execute   = 3'd2;
    localparam logic [2:0] c_st_memory    = 3'd3;
    localparam logic [2:0] c_st_writeback = 3'd4;
    localparam logic [2:0] c_st_halt      = 3'd5;
    localparam logic [2:0] c_st_fault     = 3'd6;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_halt  = 6'h3F;

    localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

    logic [2:0]             r_state;
    logic [2:0]             w_next;
    logic [7:0]             r_wait;
    logic [7:0]             w_wait_next;
    logic [COUNT_WIDTH-1:0] r_retired;
    logic                   w_retire;
    logic                   w_timeout;

    logic w_is_rtype, w_is_addi, w_is_lw, w_is_sw, w_is_beq, w_is_j, w_is_halt;
    logic w_is_legal;

    // Raw (ungated) strobes
    logic       w_memreq, w_memwrite, w_memsel, w_irwrite, w_pcwrite;
    logic [1:0] w_pcsrc;
    logic       w_alusrcimm, w_regwrite, w_memtoreg;

    assign w_is_rtype = (opcode == c_op_rtype);
    assign w_is_addi  = (opcode == c_op_addi);
    assign w_is_lw    = (opcode == c_op_lw);
    assign w_is_sw    = (opcode == c_op_sw);
    assign w_is_beq   = (opcode == c_op_beq);
    assign w_is_j     = (opcode == c_op_j);
    assign w_is_halt  = (opcode == c_op_halt);
    assign w_is_legal = w_is_rtype | w_is_addi | w_is_lw | w_is_sw | w_is_beq | w_is_j;

    // The counter has already seen MEM_TIMEOUT stalled cycles; a memReady in
    // this same cycle still wins because it is tested first below.
    assign w_timeout = (r_wait == c_timeout);

    // ------------------------------------------------------------------
    // State register and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state   <= c_st_fetch;
            r_wait    <= 8'd0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            if (w_retire) begin
                r_retired <= r_retired + COUNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            c_st_fetch: begin
                if (run) begin
                    if (memReady) begin
                        w_next = c_st_decode;
                    end else if (w_timeout) begin
                        w_next = c_st_fault;
                    end
                end
            end
            c_st_decode: begin
                if (w_is_halt) begin
                    w_next = c_st_halt;
                end else if (w_is_legal) begin
                    w_next = c_st_execute;
                end else begin
                    w_next = c_st_fault;
                end
            end
            c_st_execute: begin
                if (w_is_rtype || w_is_addi) begin
                    w_next = c_st_writeback;
                end else if (w_is_lw || w_is_sw) begin
                    w_next = c_st_memory;
                end else if (w_is_beq || w_is_j) begin
                    w_next   = c_st_fetch;
                    w_retire = 1'b1;
                end else begin
                    w_next = c_st_fault;
                end
            end
            c_st_memory: begin
                if (memReady) begin
                    if (w_is_lw) begin
                        w_next = c_st_writeback;
                    end else begin
                        w_next   = c_st_fetch;
                        w_retire = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next = c_st_fault;
                end
            end
            c_st_writeback: begin
                w_next   = c_st_fetch;
                w_retire = 1'b1;
            end
            c_st_halt:  w_next = c_st_halt;
            c_st_fault: w_next = c_st_fault;
            default:    w_next = c_st_fault;
        endcase
    end

    // Any state change clears the wait counter; that covers entry to FETCH
    // and MEMORY, and the counter only moves while a request is pending.
    always_comb begin
        w_wait_next = r_wait;
        if ((w_next != r_state) || (w_memreq && memReady)) begin
            w_wait_next = 8'd0;
        end else if (w_memreq) begin
            w_wait_next = r_wait + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_memreq    = 1'b0;
        w_memwrite  = 1'b0;
        w_memsel    = 1'b0;
        w_irwrite   = 1'b0;
        w_pcwrite   = 1'b0;
        w_pcsrc     = 2'd0;
        w_alusrcimm = 1'b0;
        w_regwrite  = 1'b0;
        w_memtoreg  = 1'b0;
        case (r_state)
            c_st_fetch: begin
                if (run) begin
                    w_memreq  = 1'b1;
                    w_irwrite = memReady;
                    w_pcwrite = memReady;
                end
            end
            c_st_execute: begin
                w_alusrcimm = w_is_addi | w_is_lw | w_is_sw;
                if (w_is_beq) begin
                    w_pcwrite = aluZero;
                    w_pcsrc   = 2'd1;
                end else if (w_is_j) begin
                    w_pcwrite = 1'b1;
                    w_pcsrc   = 2'd2;
                end
            end
            c_st_memory: begin
                w_memreq   = 1'b1;
                w_memsel   = 1'b1;
                w_memwrite = w_is_sw;
            end
            c_st_writeback: begin
                w_regwrite = 1'b1;
                w_memtoreg = w_is_lw;
            end
            default: ;
        endcase
    end

    // Strobes are forced low while reset is asserted so a request in flight
    // is dropped the moment resetN falls, not at the next clock edge.
    assign memReq       = w_memreq    & resetN;
    assign memWrite     = w_memwrite  & resetN;
    assign memSel       = w_memsel    & resetN;
    assign irWrite      = w_irwrite   & resetN;
    assign pcWrite      = w_pcwrite   & resetN;
    assign pcSrc        = w_pcsrc     & {2{resetN}};
    assign aluSrcImm    = w_alusrcimm & resetN;
    assign regWrite     = w_regwrite  & resetN;
    assign memToReg     = w_memtoreg  & resetN;
    assign state        = r_state;
    assign halted       = (r_state == c_st_halt);
    assign fault        = (r_state == c_st_fault);
    assign retiredCount = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_sequencer
// Purpose  : Directed self-checking bench for control_sequencer, built with
//            MEM_TIMEOUT=4 and COUNT_WIDTH=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    logic       clk;
    logic       resetN;
    logic       run;
    logic [5:0] opcode;
    logic       aluZero;
    logic       memReady;
    logic       memReq, memWrite, memSel, irWrite, pcWrite;
    logic [1:0] pcSrc;
    logic       aluSrcImm, regWrite, memToReg;
    logic [2:0] state;
    logic       halted, fault;
    logic [2:0] retiredCount;

    logic [9:0] strobes;
    assign strobes = {memReq, memWrite, memSel, irWrite, pcWrite, pcSrc,
                      aluSrcImm, regWrite, memToReg};

    int n_checks = 0;
    int n_errors = 0;

    control_sequencer #(
        .MEM_TIMEOUT(4),
        .COUNT_WIDTH(3)
    ) u_dut (
        .clk         (clk),
        .resetN      (resetN),
        .run         (run),
        .opcode      (opcode),
        .aluZero     (aluZero),
        .memReady    (memReady),
        .memReq      (memReq),
        .memWrite    (memWrite),
        .memSel      (memSel),
        .irWrite     (irWrite),
        .pcWrite     (pcWrite),
        .pcSrc       (pcSrc),
        .aluSrcImm   (aluSrcImm),
        .regWrite    (regWrite),
        .memToReg    (memToReg),
        .state       (state),
        .halted      (halted),
        .fault       (fault),
        .retiredCount(retiredCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across one edge, check the reset state, then release.
    task automatic do_reset();
        resetN = 1'b0;
        #1;
        check("reset strobes", 32'(strobes), 32'd0);
        step();
        check("reset state", 32'(state), 32'd0);
        check("reset count", 32'(retiredCount), 32'd0);
        resetN = 1'b1;
    endtask

    // Run one instruction with memReady tied high; trace packs the expected
    // state of each cycle, 3 bits per cycle, first cycle in the low bits.
    task automatic do_instr(input logic [5:0] op, input logic zero, input int n,
                            input logic [14:0] trace);
        logic [14:0] t;
        t = trace;
        for (int i = 0; i < n; i++) begin
            opcode   = op;
            aluZero  = zero;
            memReady = 1'b1;
            #1;
            check($sformatf("trace op%0h c%0d", op, i), 32'(state), 32'(t[3*i +: 3]));
            if (i == 2 && op == 6'h04) begin
                check("beq pcWrite", 32'(pcWrite), 32'd1);
                check("beq pcSrc", 32'(pcSrc), 32'd1);
            end
            if (i == 2 && op == 6'h02) begin
                check("j pcWrite", 32'(pcWrite), 32'd1);
                check("j pcSrc", 32'(pcSrc), 32'd2);
            end
            step();
        end
    endtask

    initial begin
        int n_ir;
        int n_rw;
        logic mtr;

        resetN   = 1'b0;
        run      = 1'b1;
        opcode   = 6'h00;
        aluZero  = 1'b0;
        memReady = 1'b0;
        #2;

        // ---------------- latency with memReady high ----------------
        do_reset();
        do_instr(6'h08, 1'b0, 4, {3'd0, 3'd4, 3'd2, 3'd1, 3'd0});
        do_instr(6'h23, 1'b0, 5, {3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
        do_instr(6'h2B, 1'b0, 4, {3'd0, 3'd3, 3'd2, 3'd1, 3'd0});
        do_instr(6'h04, 1'b1, 3, {6'd0, 3'd2, 3'd1, 3'd0});
        do_instr(6'h02, 1'b0, 3, {6'd0, 3'd2, 3'd1, 3'd0});
        check("latency count", 32'(retiredCount), 32'd5);

        // ---------------- illegal opcode ----------------
        do_instr(6'h15, 1'b0, 2, {9'd0, 3'd1, 3'd0});
        check("illegal state", 32'(state), 32'd6);
        check("illegal fault", 32'(fault), 32'd1);
        check("illegal count", 32'(retiredCount), 32'd5);
        check("illegal strobes", 32'(strobes), 32'd0);

        // ---------------- halt ----------------
        do_reset();
        do_instr(6'h3F, 1'b0, 2, {9'd0, 3'd1, 3'd0});
        for (int i = 0; i < 20; i++) begin
            memReady = 1'b1;
            #1;
            check($sformatf("halt c%0d", i), 32'({state, halted, fault, strobes}),
                  32'({3'd5, 1'b1, 1'b0, 10'd0}));
            step();
        end

        // ---------------- lw with wait states ----------------
        do_reset();
        n_ir = 0;
        n_rw = 0;
        mtr  = 1'b0;
        for (int c = 0; c < 11; c++) begin
            opcode   = 6'h23;
            memReady = (c == 3 || c == 9);
            #1;
            if (irWrite) n_ir++;
            if (regWrite) begin
                n_rw++;
                mtr = memToReg;
            end
            step();
        end
        check("wait state", 32'(state), 32'd0);
        check("wait count", 32'(retiredCount), 32'd1);
        check("wait irWrite pulses", 32'(n_ir), 32'd1);
        check("wait regWrite pulses", 32'(n_rw), 32'd1);
        check("wait memToReg", 32'(mtr), 32'd1);

        // ---------------- fetch timeout ----------------
        do_reset();
        memReady = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("timeout pre state", 32'(state), 32'd0);
        step();
        check("timeout state", 32'(state), 32'd6);
        check("timeout fault", 32'(fault), 32'd1);
        memReady = 1'b1;
        step();
        check("fault absorbing", 32'(state), 32'd6);
        check("fault memReq", 32'(memReq), 32'd0);

        // memReady arrives in the cycle where the counter has hit the limit
        do_reset();
        memReady = 1'b0;
        for (int i = 0; i < 4; i++) step();
        memReady = 1'b1;
        #1;
        check("late ready irWrite", 32'(irWrite), 32'd1);
        step();
        check("late ready state", 32'(state), 32'd1);
        check("late ready fault", 32'(fault), 32'd0);

        // ---------------- reset during sw memory wait ----------------
        do_reset();
        do_instr(6'h02, 1'b0, 3, {6'd0, 3'd2, 3'd1, 3'd0});
        opcode   = 6'h2B;
        memReady = 1'b1;
        step();
        step();
        step();
        memReady = 1'b0;
        #1;
        check("sw mem state", 32'(state), 32'd3);
        check("sw mem write", 32'({memReq, memWrite, memSel}), 32'b111);
        check("sw pre-reset count", 32'(retiredCount), 32'd1);
        step();
        #2;
        resetN = 1'b0;
        #1;
        check("async rst state", 32'(state), 32'd0);
        check("async rst count", 32'(retiredCount), 32'd0);
        check("async rst memReq", 32'(memReq), 32'd0);
        check("async rst memWrite", 32'(memWrite), 32'd0);
        run = 1'b0;
        @(posedge clk);
        #3;
        resetN = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            memReady = 1'b1;
            #1;
            check($sformatf("idle memReq c%0d", i), 32'(memReq), 32'd0);
            check($sformatf("idle state c%0d", i), 32'(state), 32'd0);
            step();
        end
        run = 1'b1;
        #1;
        check("run memReq", 32'(memReq), 32'd1);
        step();
        check("run decode", 32'(state), 32'd1);

        // ---------------- retired counter wrap ----------------
        do_reset();
        for (int k = 0; k < 8; k++) begin
            do_instr(6'h02, 1'b0, 3, {6'd0, 3'd2, 3'd1, 3'd0});
            if (k == 6) check("wrap count 7", 32'(retiredCount), 32'd7);
        end
        check("wrap count 0", 32'(retiredCount), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle control FSM for the 32-bit Microprocessor.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the enables for the PC, instruction register, register file, ALU source mux and the single shared memory port.
- Handshakes with memory through memReq/memReady and retires instructions into a counter for bench observation.

Parameters:
- MEM_TIMEOUT, 16: cycles memReady may stay low during one request before FAULT; legal range 1..255.
- COUNT_WIDTH, 32: width of retiredCount.

Ports:
- clk  input  1  system clock, rising edge.
- resetN  input  1  asynchronous, active-low reset.
- run  input  1  when low, FETCH issues no new request.
- opcode  input  6  instruction register bits [31:26].
- aluZero  input  1  ALU zero flag, valid in EXECUTE.
- memReady  input  1  memory completes the current request this cycle.
- memReq  output  1  memory request active.
- memWrite  output  1  request is a write; valid only while memReq=1.
- memSel  output  1  memory address source: 0 = PC, 1 = ALU result.
- irWrite  output  1  load the instruction register.
- pcWrite  output  1  load the PC.
- pcSrc  output  2  PC source: 0 = PC+4, 1 = branch target, 2 = jump target.
- aluSrcImm  output  1  ALU operand B is the sign-extended immediate.
- regWrite  output  1  register file write enable.
- memToReg  output  1  writeback data comes from memory.
- state  output  3  current state encoding.
- halted  output  1  high in HALT.
- fault  output  1  high in FAULT.
- retiredCount  output  COUNT_WIDTH  number of retired instructions.

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5, FAULT=6. Encoding 7 is unreachable and recovers to FAULT.
- Opcode set:
  - 0x00 R-type.
  - 0x08 addi.
  - 0x23 lw.
  - 0x2B sw.
  - 0x04 beq.
  - 0x02 j.
  - 0x3F halt.
  - Any other opcode is illegal.
- Reset (resetN=0, asynchronous):
  - state=FETCH, retiredCount=0, wait counter=0.
  - All strobe outputs are 0 while resetN=0.
  - Reset mid-request aborts the request immediately; no irWrite, pcWrite or regWrite occurs.
- Strobes are combinational decodes of state, opcode, aluZero and memReady. The state register and counters update on the rising edge of clk.
- FETCH:
  - When run=1: memReq=1, memWrite=0, memSel=0.
  - In the cycle memReady=1: irWrite=1, pcWrite=1, pcSrc=0, next state DECODE.
  - When run=0: memReq=0, stay in FETCH, wait counter holds at 0.
- DECODE:
  - Lasts 1 cycle. No strobes are asserted.
  - halt -> HALT. Illegal opcode -> FAULT. Any other opcode -> EXECUTE.
- EXECUTE (1 cycle):
  - aluSrcImm=1 for addi, lw and sw.
  - R-type and addi -> WRITEBACK.
  - lw and sw -> MEMORY.
  - beq: pcWrite=aluZero, pcSrc=1, -> FETCH, retire.
  - j: pcWrite=1, pcSrc=2, -> FETCH, retire.
- MEMORY:
  - memReq=1, memSel=1, memWrite=1 for sw.
  - Hold until memReady=1.
  - lw -> WRITEBACK.
  - sw -> FETCH, retire in the memReady cycle.
- WRITEBACK:
  - Lasts 1 cycle with regWrite=1.
  - memToReg=1 for lw, 0 otherwise.
  - -> FETCH, retire.
- Retire: retiredCount increments by 1 on the clock edge that leaves the final state of an instruction. It wraps from all-ones to 0. halt does not retire.
- Wait counter:
  - Clears on entry to FETCH or MEMORY and whenever memReady=1.
  - Increments each cycle memReq=1 and memReady=0.
  - When it reaches MEM_TIMEOUT with memReady still 0, the next state is FAULT.
  - memReady=1 in the timeout cycle takes priority: the request completes and no fault is raised.
- HALT and FAULT are absorbing until reset. All strobes are 0 there, and halted or fault is held high respectively.
- memReady while memReq=0 is ignored.
- Latency with memReady tied high (cycles):
  - R-type and addi: 4.
  - lw: 5.
  - sw: 4.
  - beq and j: 3.

Test Plan:
- Latency: memReady=1, run=1, opcodes addi, lw, sw, beq (aluZero=1), j in sequence.
  - Required: state trace 0-1-2-4, 0-1-2-3-4, 0-1-2-3, 0-1-2, 0-1-2.
  - Required: retiredCount=5 after 19 cycles; pcSrc=1 with pcWrite=1 in the beq EXECUTE cycle.
- Wait states: lw with memReady low for 3 cycles in both FETCH and MEMORY.
  - Required: 11 cycles total, irWrite pulses exactly once, regWrite pulses exactly once, memToReg=1.
- Timeout: MEM_TIMEOUT=4, memReady held 0 in FETCH.
  - Required: fault=1 and state=6 after the 5th cycle; memReady=1 on exactly the 4th wait cycle instead gives DECODE with no fault.
- Illegal opcode 0x15 -> DECODE then FAULT; retiredCount unchanged. Opcode 0x3F -> HALT, halted=1; it stays there for 20 cycles with no strobes.
- Reset mid-MEMORY: drop resetN asynchronously between clock edges during a sw wait.
  - Required: state=0, retiredCount=0 and memReq=0 immediately, and no memWrite pulse.
  - After release with run=0: memReq stays 0. Raising run starts a fetch on the next cycle.
- Wrap: COUNT_WIDTH=3 with eight j instructions -> retiredCount returns to 0.
